// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx: SPI target model of an SSD1306 OLED controller.
// It synchronises the SPI pins into clk_in, assembles MSB-first bytes, and decodes
// command/argument framing. It tracks display state and addressing pointers, and
// emits GDDRAM write strobes for data bytes.
// Optional feature: define SSD1306_RX_FRAME_CHECK_EN to pulse frame_error when CS
// rises mid-byte. Otherwise frame_error is tied low.
`timescale 1ns/1ps

module ssd1306_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       spi_csn,
  input  logic                       spi_sck,
  input  logic                       spi_mosi,
  input  logic                       spi_dc,
  output logic                       rx_valid,
  output logic [7:0]                 rx_byte,
  output logic                       rx_is_data,
  output logic                       cmd_start,
  output logic [2:0]                 arg_index,
  output logic                       wr_en,
  output logic [$clog2(PAGES)-1:0]   wr_page,
  output logic [$clog2(COLS)-1:0]    wr_col,
  output logic [7:0]                 wr_data,
  output logic                       display_on,
  output logic [7:0]                 contrast,
  output logic                       charge_pump_en,
  output logic                       frame_error
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  localparam logic ST_CMD  = 1'b0;
  localparam logic ST_ARGS = 1'b1;

  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);

  // Number of argument bytes that follow each opcode; unknown opcodes take none.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'h20, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:         arg_count = 3'd1;
      8'h21, 8'h22, 8'hA3:                arg_count = 3'd2;
      8'h29, 8'h2A:                       arg_count = 3'd5;
      8'h26, 8'h27:                       arg_count = 3'd6;
      default:                            arg_count = 3'd0;
    endcase
  endfunction

  // Synchroniser chains: shift toward the MSB, and the MSB is the synchronised value.
  logic [SYNC_STAGES-1:0] csn_sync_q, sck_sync_q, mosi_sync_q, dc_sync_q;
  logic csn_s, sck_s, mosi_s, dc_s;
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // Receiver state
  logic          sck_prev_q, csn_prev_q, armed_q, armed_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;

  // Command FSM state
  logic          state_q, state_d;
  logic [7:0]    op_q, op_d, arg0_q, arg0_d;
  logic [2:0]    args_left_q, args_left_d, arg_idx_q, arg_idx_d;

  // Display state
  logic          display_on_q, display_on_d, cp_q, cp_d;
  logic [7:0]    contrast_q, contrast_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

  // Registered outputs
  logic          rx_valid_q, rx_valid_d, rx_is_data_q, rx_is_data_d;
  logic          cmd_start_q, cmd_start_d, wr_en_q, wr_en_d;
  logic [7:0]    rx_byte_q, rx_byte_d, wr_data_q, wr_data_d;
  logic [2:0]    arg_index_q, arg_index_d;
  logic [PW-1:0] wr_page_q, wr_page_d;
  logic [CW-1:0] wr_col_q, wr_col_d;

  // Combinational helpers
  logic          bit_accept, byte_done, col_last, page_last;
  logic [2:0]    cnt_next, n_args;
  logic [7:0]    rx_b, first_arg, col8;

  // Next-state logic: bit assembly, command decode, and pointer advance.
  // NOTE: every signal written here receives a default first, so no path can infer a latch.
  always_comb begin
    armed_d      = armed_q | csn_s;
    shift_d      = shift_q;
    state_d      = state_q;
    op_d         = op_q;
    arg0_d       = arg0_q;
    args_left_d  = args_left_q;
    arg_idx_d    = arg_idx_q;
    display_on_d = display_on_q;
    cp_d         = cp_q;
    contrast_d   = contrast_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    rx_valid_d   = 1'b0;
    wr_en_d      = 1'b0;
    rx_byte_d    = rx_byte_q;
    rx_is_data_d = rx_is_data_q;
    cmd_start_d  = cmd_start_q;
    arg_index_d  = arg_index_q;
    wr_page_d    = wr_page_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    n_args       = arg_count(rx_b);
    first_arg    = (arg_idx_q == 3'd0) ? rx_b : arg0_q;
    col8         = 8'(col_q);
    col_last     = (col_q == col_end_q) || (col_q == COL_MAX);
    page_last    = (page_q == page_end_q) || (page_q == PAGE_MAX);

    // A rise still counts when it reaches the synchroniser together with CS going high.
    bit_accept = armed_q && sck_s && !sck_prev_q && (!csn_s || !csn_prev_q);
    cnt_next   = bit_accept ? bit_cnt_q + 3'd1 : bit_cnt_q;
    byte_done  = bit_accept && (bit_cnt_q == 3'd7);
    rx_b       = {shift_q, mosi_s};
    bit_cnt_d  = csn_s ? 3'd0 : cnt_next;
    if (bit_accept) shift_d = rx_b[6:0];

    if (byte_done) begin
      rx_valid_d   = 1'b1;
      rx_byte_d    = rx_b;
      rx_is_data_d = dc_s;
      cmd_start_d  = 1'b0;
      arg_index_d  = 3'd0;
      if (dc_s) begin
        // A data byte cancels any half-received command and goes to GDDRAM.
        state_d     = ST_CMD;
        args_left_d = 3'd0;
        wr_en_d     = 1'b1;
        wr_page_d   = page_q;
        wr_col_d    = col_q;
        wr_data_d   = rx_b;
        case (mode_q)
          2'd0: begin
            if (col_last) begin
              col_d  = col_start_q;
              page_d = page_last ? page_start_q : page_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          2'd1: begin
            if (page_last) begin
              page_d = page_start_q;
              col_d  = col_last ? col_start_q : col_q + 1'b1;
            end else begin
              page_d = page_q + 1'b1;
            end
          end
          default: col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
        endcase
      end else if (state_q == ST_CMD) begin
        cmd_start_d = 1'b1;
        if (n_args != 3'd0) begin
          state_d     = ST_ARGS;
          op_d        = rx_b;
          args_left_d = n_args;
          arg_idx_d   = 3'd0;
        end else begin
          if (rx_b == 8'hAF) display_on_d = 1'b1;
          if (rx_b == 8'hAE) display_on_d = 1'b0;
          if (mode_q == 2'd2) begin
            if (rx_b[7:3] == 5'b10110) page_d = PW'(rx_b[2:0]);
            if (rx_b[7:4] == 4'h0)     col_d  = CW'({col8[7:4], rx_b[3:0]});
            if (rx_b[7:4] == 4'h1)     col_d  = CW'({rx_b[3:0], col8[3:0]});
          end
        end
      end else begin
        arg_index_d = arg_idx_q;
        if (arg_idx_q == 3'd0) arg0_d = rx_b;
        if (args_left_q == 3'd1) begin
          state_d     = ST_CMD;
          args_left_d = 3'd0;
          case (op_q)
            8'h81: contrast_d = rx_b;
            8'h8D: cp_d = rx_b[2];
            8'h20: if (rx_b[1:0] != 2'd3) mode_d = rx_b[1:0];
            8'h21: begin
              col_start_d = CW'(first_arg);
              col_end_d   = CW'(rx_b);
              col_d       = CW'(first_arg);
            end
            8'h22: begin
              page_start_d = PW'(first_arg);
              page_end_d   = PW'(rx_b);
              page_d       = PW'(first_arg);
            end
            default: ;
          endcase
        end else begin
          args_left_d = args_left_q - 3'd1;
          arg_idx_d   = arg_idx_q + 3'd1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      csn_sync_q   <= '0;
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      dc_sync_q    <= '0;
      sck_prev_q   <= 1'b0;
      csn_prev_q   <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      state_q      <= ST_CMD;
      op_q         <= 8'd0;
      arg0_q       <= 8'd0;
      args_left_q  <= 3'd0;
      arg_idx_q    <= 3'd0;
      display_on_q <= 1'b0;
      cp_q         <= 1'b0;
      contrast_q   <= 8'h7F;
      mode_q       <= 2'd2;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_MAX;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'd0;
      rx_is_data_q <= 1'b0;
      cmd_start_q  <= 1'b0;
      arg_index_q  <= 3'd0;
      wr_en_q      <= 1'b0;
      wr_page_q    <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= 8'd0;
    end else begin
      csn_sync_q   <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q    <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
      sck_prev_q   <= sck_s;
      csn_prev_q   <= csn_s;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      state_q      <= state_d;
      op_q         <= op_d;
      arg0_q       <= arg0_d;
      args_left_q  <= args_left_d;
      arg_idx_q    <= arg_idx_d;
      display_on_q <= display_on_d;
      cp_q         <= cp_d;
      contrast_q   <= contrast_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      rx_is_data_q <= rx_is_data_d;
      cmd_start_q  <= cmd_start_d;
      arg_index_q  <= arg_index_d;
      wr_en_q      <= wr_en_d;
      wr_page_q    <= wr_page_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
    end
  end

`ifdef SSD1306_RX_FRAME_CHECK_EN
  logic frame_error_q;
  // A CS rise that leaves a partial byte behind is flagged for one cycle.
  always_ff @(posedge clk_in) begin
    if (reset_in) frame_error_q <= 1'b0;
    else          frame_error_q <= csn_s && !csn_prev_q && (cnt_next != 3'd0);
  end
  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

  assign rx_valid       = rx_valid_q;
  assign rx_byte        = rx_byte_q;
  assign rx_is_data     = rx_is_data_q;
  assign cmd_start      = cmd_start_q;
  assign arg_index      = arg_index_q;
  assign wr_en          = wr_en_q;
  assign wr_page        = wr_page_q;
  assign wr_col         = wr_col_q;
  assign wr_data        = wr_data_q;
  assign display_on     = display_on_q;
  assign contrast       = contrast_q;
  assign charge_pump_en = cp_q;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Scoreboard bench for ssd1306_spi_rx. SPI stimulus pushes expected responses from a
// behavioural display model. An independent monitor pops and compares them whenever
// rx_valid or frame_error fires.
`timescale 1ns/1ps

module tb_ssd1306_spi_rx;
  localparam int SYNC_STAGES = 2;
  localparam int COLS        = 128;
  localparam int PAGES       = 8;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk_in = 1'b0, reset_in = 1'b1;
  logic       spi_csn = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0;
  logic       rx_valid, rx_is_data, cmd_start, wr_en, display_on, charge_pump_en, frame_error;
  logic [7:0] rx_byte, wr_data, contrast;
  logic [2:0] arg_index, wr_page;
  logic [6:0] wr_col;

  ssd1306_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .COLS(COLS), .PAGES(PAGES)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_is_data(rx_is_data), .cmd_start(cmd_start), .arg_index(arg_index),
    .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
    .display_on(display_on), .contrast(contrast), .charge_pump_en(charge_pump_en),
    .frame_error(frame_error)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       is_data;
    logic       cmd_start;
    int         arg_index;
    logic       wr_en;
    int         page;
    int         col;
    logic [7:0] contrast;
    logic       disp;
    logic       cp;
    int         rise_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fe_q[$];
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural display model ----------------
  int nargs[256];
  int m_disp, m_contrast, m_cp, m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  int m_op, m_need;
  int m_args[$];

  task automatic model_reset();
    m_disp = 0; m_contrast = 'h7F; m_cp = 0; m_mode = 2;
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_op = 0; m_need = 0; m_args.delete();
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b, output exp_t e);
    e.b = b; e.is_data = dc; e.cmd_start = 0; e.arg_index = 0;
    e.wr_en = 0; e.page = m_page; e.col = m_col;
    if (dc) begin
      m_need = 0; m_args.delete();
      e.wr_en = 1;
      if (m_mode == 0) begin
        if (m_col == m_ce || m_col == COLS - 1) begin
          m_col = m_cs;
          m_page = (m_page == m_pe || m_page == PAGES - 1) ? m_ps : m_page + 1;
        end else m_col++;
      end else if (m_mode == 1) begin
        if (m_page == m_pe || m_page == PAGES - 1) begin
          m_page = m_ps;
          m_col = (m_col == m_ce || m_col == COLS - 1) ? m_cs : m_col + 1;
        end else m_page++;
      end else begin
        m_col = (m_col == COLS - 1) ? 0 : m_col + 1;
      end
    end else if (m_need == 0) begin
      e.cmd_start = 1;
      if (nargs[b] > 0) begin
        m_op = b; m_need = nargs[b]; m_args.delete();
      end else begin
        if (b == 8'hAF) m_disp = 1;
        if (b == 8'hAE) m_disp = 0;
        if (m_mode == 2) begin
          if (b >= 8'hB0 && b <= 8'hB7) m_page = b - 8'hB0;
          if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
          if (b >= 8'h10 && b <= 8'h1F) m_col = ((b - 16) * 16 + (m_col % 16)) % COLS;
        end
      end
    end else begin
      e.arg_index = m_args.size();
      m_args.push_back(b);
      if (m_args.size() == m_need) begin
        case (m_op)
          'h81: m_contrast = b;
          'h8D: m_cp = (b / 4) % 2;
          'h20: if (b % 4 != 3) m_mode = b % 4;
          'h21: begin m_cs = m_args[0] % COLS; m_ce = b % COLS; m_col = m_cs; end
          'h22: begin m_ps = m_args[0] % PAGES; m_pe = b % PAGES; m_page = m_ps; end
          default: ;
        endcase
        m_need = 0;
      end
    end
    e.contrast = m_contrast; e.disp = m_disp; e.cp = m_cp; e.rise_cyc = 0;
  endtask

  // ---------------- SPI drivers ----------------
  task automatic cs_low();
    spi_csn = 1'b0; repeat (4) @(negedge clk_in);
  endtask

  task automatic cs_high();
    spi_csn = 1'b1; repeat (4) @(negedge clk_in);
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b, input bit tight_cs);
    exp_t e;
    model_byte(dc, b, e);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (3) @(negedge clk_in);
      if (i == 0) begin
        e.rise_cyc = cyc;
        exp_q.push_back(e);
        if (tight_cs) spi_csn = 1'b1;
      end
      spi_sck = 1'b1;
      repeat (3) @(negedge clk_in);
      spi_sck = 1'b0;
    end
  endtask

  task automatic raw_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk_in);
      spi_sck = 1'b1;
      repeat (3) @(negedge clk_in);
      spi_sck = 1'b0;
    end
  endtask

  task automatic partial_frame(input int n);
    raw_bits(n);
    repeat (2) @(negedge clk_in);
`ifdef SSD1306_RX_FRAME_CHECK_EN
    fe_q.push_back(cyc);
`endif
    cs_high();
    cs_low();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || fe_q.size() != 0); i++) @(negedge clk_in);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected rx_valid: byte 0x%0h, nothing expected", rx_byte);
        end else begin
          e = exp_q.pop_front();
          check("rx_latency", cyc - e.rise_cyc, LAT);
          check("rx_byte", rx_byte, e.b);
          check("rx_is_data", rx_is_data, e.is_data);
          check("cmd_start", cmd_start, e.cmd_start);
          if (!e.is_data && !e.cmd_start) check("arg_index", arg_index, e.arg_index);
          check("wr_en", wr_en, e.wr_en);
          if (e.wr_en) begin
            check("wr_page", wr_page, e.page);
            check("wr_col", wr_col, e.col);
            check("wr_data", wr_data, e.b);
          end
          check("display_on", display_on, e.disp);
          check("contrast", contrast, e.contrast);
          check("charge_pump_en", charge_pump_en, e.cp);
        end
      end else if (wr_en) begin
        checks++; errors++;
        $display("FAIL stray wr_en: wr_en=1 without rx_valid");
      end
      if (frame_error) begin
        if (fe_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected frame_error: got 1, expected 0");
        end else begin
          check("frame_error_latency", cyc - fe_q.pop_front(), LAT);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] cmd_list [0:15] = '{8'hAF, 8'hAE, 8'h81, 8'h8D, 8'h20, 8'h21, 8'h22, 8'hA8,
                                  8'hD3, 8'hA3, 8'h29, 8'h26, 8'hB0, 8'h00, 8'h10, 8'hA5};

  task automatic check_reset_values();
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_byte", rx_byte, 0);
    check("reset wr_en", wr_en, 0);
    check("reset wr_page", wr_page, 0);
    check("reset wr_col", wr_col, 0);
    check("reset display_on", display_on, 0);
    check("reset contrast", contrast, 8'h7F);
    check("reset charge_pump_en", charge_pump_en, 0);
    check("reset frame_error", frame_error, 0);
  endtask

  initial begin
    logic [7:0] op;
    int r, n;
    for (int i = 0; i < 256; i++) nargs[i] = 0;
    nargs['h81] = 1; nargs['h8D] = 1; nargs['h20] = 1; nargs['hA8] = 1; nargs['hD3] = 1;
    nargs['hD5] = 1; nargs['hD9] = 1; nargs['hDA] = 1; nargs['hDB] = 1;
    nargs['h21] = 2; nargs['h22] = 2; nargs['hA3] = 2;
    nargs['h29] = 5; nargs['h2A] = 5; nargs['h26] = 6; nargs['h27] = 6;
    model_reset();

    repeat (5) @(negedge clk_in);
    reset_in = 1'b0;
    check_reset_values();
    repeat (4) @(negedge clk_in);

    // Directed scenarios
    cs_low();
    send_byte(0, 8'hAF, 0); send_byte(0, 8'hAE, 0);
    send_byte(0, 8'h81, 0); send_byte(0, 8'hCF, 0);
    send_byte(0, 8'h8D, 0); send_byte(0, 8'h14, 0);
    send_byte(0, 8'h20, 0); send_byte(0, 8'h00, 0);
    send_byte(0, 8'h21, 0); send_byte(0, 8'h7E, 0); send_byte(0, 8'h7F, 0);
    send_byte(0, 8'h22, 0); send_byte(0, 8'h06, 0); send_byte(0, 8'h07, 0);
    for (int i = 0; i < 5; i++) send_byte(1, 8'($urandom), 0);
    send_byte(0, 8'h20, 0); send_byte(0, 8'h02, 0);
    send_byte(0, 8'hB3, 0); send_byte(0, 8'h05, 0); send_byte(0, 8'h10, 0);
    send_byte(1, 8'hAA, 0);
    partial_frame(5);
    send_byte(0, 8'hA5, 0);
    send_byte(1, 8'h3C, 1);
    repeat (4) @(negedge clk_in);
    cs_low();

    // Randomised traffic
    for (int it = 0; it < 220; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        cs_high(); cs_low();
      end else if (r < 12) begin
        partial_frame($urandom_range(1, 7));
      end else if (r < 16) begin
        send_byte(1'($urandom_range(0, 1)), 8'($urandom), 1);
        repeat (4) @(negedge clk_in);
        cs_low();
      end else if (r < 50) begin
        send_byte(1, 8'($urandom), 0);
      end else begin
        op = cmd_list[$urandom_range(0, 15)];
        if (op == 8'hB0) op = 8'hB0 + 8'($urandom_range(0, 7));
        if (op == 8'h00) op = 8'($urandom_range(0, 15));
        if (op == 8'h10) op = 8'h10 + 8'($urandom_range(0, 7));
        if (op[7:5] == 3'b000 || op[7:3] == 5'b10110) if (m_mode != 2) op = 8'hAF;
        send_byte(0, op, 0);
        n = nargs[op];
        for (int a = 0; a < n; a++) begin
          if ($urandom_range(0, 19) == 0) begin
            send_byte(1, 8'($urandom), 0);
            break;
          end
          case (op)
            8'h21:   send_byte(0, 8'($urandom_range(0, COLS - 1)), 0);
            8'h22:   send_byte(0, 8'($urandom_range(0, PAGES - 1)), 0);
            8'h20:   send_byte(0, 8'($urandom_range(0, 3)), 0);
            default: send_byte(0, 8'($urandom), 0);
          endcase
        end
      end
    end

    // Reset mid-byte with CS held low
    drain();
    check("queue empty before reset", exp_q.size(), 0);
    raw_bits(4);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    model_reset();
    check_reset_values();
    raw_bits(8);
    repeat (6) @(negedge clk_in);
    cs_high();
    cs_low();
    send_byte(0, 8'h81, 0);
    send_byte(1, 8'h55, 0);
    cs_high();

    drain();
    check("expected rx left over", exp_q.size(), 0);
    check("expected frame_error left over", fe_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
